// File: rtl/mips_mem_pkg.sv
// Shared types for the single-port memory arbiter: FSM states, grant owner, counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_mem_pkg;

    // IDLE: free to grant this cycle. WAIT: one read outstanding, memory busy.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Which requester owns the current / outstanding memory access.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Legal read-latency range of the attached RAM and the counter width it needs.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int LAT_W      = $clog2(RD_LAT_MAX + 1);

    // Streak counter width; MAX_D_STREAK may be at most 15.
    localparam int STREAK_W   = 4;

endpackage

// File: rtl/mem_grant_select.sv
// Priority select between fetch and data requesters with a data-streak limiter.
// Latency: combinational owner/grant; streak counter updates at the clock edge.
// Backpressure: grants only while i_grant_ok is high; requesters simply keep requesting.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   i_grant_ok      arbiter is able to issue a memory access this cycle
//   i_fetch_req     fetch port is requesting
//   i_data_req      data port is requesting (read or write)
//   o_grant         a memory access is issued this cycle
//   o_owner         port that owns the access (meaningful while o_grant)
module mem_grant_select
    import mips_mem_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
)(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_grant_ok,
    input  logic   i_fetch_req,
    input  logic   i_data_req,
    output logic   o_grant,
    output owner_e o_owner
);

    logic [STREAK_W-1:0] r_streak;
    logic                w_fetch_due;

    // Once data has won MAX_D_STREAK times in a row against a waiting fetch,
    // the fetch takes the next slot regardless of data requests.
    assign w_fetch_due = i_fetch_req && (r_streak == STREAK_W'(MAX_D_STREAK));
    assign o_owner     = (i_data_req && !w_fetch_due) ? OWN_D : OWN_I;
    assign o_grant     = i_grant_ok && (i_data_req || i_fetch_req);

    // The streak only counts data wins that actually starved a fetch, so it is
    // cleared whenever no fetch is waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (!i_fetch_req) begin
            r_streak <= '0;
        end else if (o_grant) begin
            if (o_owner == OWN_I) begin
                r_streak <= '0;
            end else if (r_streak != STREAK_W'(MAX_D_STREAK)) begin
                r_streak <= r_streak + STREAK_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port and the data port.
// Latency: grant in the request cycle; writes complete in that cycle, reads return RD_LATENCY cycles later.
// Backpressure: i_stall/d_stall stay high while the port's request is pending and not completing.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   i_read_en, i_addr             fetch request and address
//   i_instr_out, i_valid, i_stall fetched word, one-cycle return pulse, fetch stall
//   d_read_en, d_write_en         data read / write request (write wins if both)
//   d_addr, d_write_data          data address and store data
//   d_data_out, d_valid, d_stall  load word, return/write-accept pulse, data stall
//   mem_en, mem_we, mem_addr,     memory access strobe, write enable, address,
//   mem_wdata, mem_rdata          write data, read data (RD_LATENCY after mem_en)
// RD_LATENCY must lie in RD_LAT_MIN..RD_LAT_MAX; MAX_D_STREAK in 1..15.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int MAX_D_STREAK = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_instr_out,
    output logic              i_valid,
    output logic              i_stall,
    input  logic              d_read_en,
    input  logic              d_write_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_write_data,
    output logic [DATA_W-1:0] d_data_out,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [LAT_W-1:0]  r_lat_cnt;
    owner_e            r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_i_instr;
    logic [DATA_W-1:0] r_d_data;

    logic              w_d_req;
    logic              w_ret;
    logic              w_grant_ok;
    logic              w_grant;
    owner_e            w_owner;
    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_gnt_wr;
    logic              w_gnt_rd;
    logic              w_i_ret;
    logic              w_d_ret;
    logic [ADDR_W-1:0] w_sel_addr;

    assign w_d_req = d_read_en || d_write_en;

    // The outstanding read completes in the cycle the counter would step from 1 to 0;
    // mem_rdata is valid in exactly that cycle.
    assign w_ret      = rst && (r_state == WAIT) && (r_lat_cnt == LAT_W'(1));
    // The memory is free in IDLE, and also in the return cycle, so reads run back to back.
    assign w_grant_ok = rst && ((r_state == IDLE) || w_ret);

    mem_grant_select #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_grant_select (
        .clk         (clk),
        .rst         (rst),
        .i_grant_ok  (w_grant_ok),
        .i_fetch_req (i_read_en),
        .i_data_req  (w_d_req),
        .o_grant     (w_grant),
        .o_owner     (w_owner)
    );

    assign w_gnt_d    = w_grant && (w_owner == OWN_D);
    assign w_gnt_i    = w_grant && (w_owner == OWN_I);
    // A simultaneous read+write request is served as a write only.
    assign w_gnt_wr   = w_gnt_d && d_write_en;
    assign w_gnt_rd   = (w_gnt_i || w_gnt_d) && !w_gnt_wr;
    assign w_i_ret    = w_ret && (r_owner == OWN_I);
    assign w_d_ret    = w_ret && (r_owner == OWN_D);
    assign w_sel_addr = w_gnt_d ? d_addr : i_addr;

    // Next state plus all outputs. Every output is forced to zero while in reset,
    // including the cycle in which reset is first sampled.
    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_valid     = 1'b0;
        d_valid     = 1'b0;
        i_instr_out = '0;
        d_data_out  = '0;
        i_stall     = 1'b0;
        d_stall     = 1'b0;

        case (r_state)
            IDLE:    if (w_gnt_rd) w_state_nxt = WAIT;
            WAIT:    if (w_ret)    w_state_nxt = w_gnt_rd ? WAIT : IDLE;
            default: w_state_nxt = IDLE;
        endcase

        if (rst) begin
            mem_en      = w_grant;
            mem_we      = w_gnt_wr;
            // Outside a grant the address of the last access is held for observability.
            mem_addr    = w_grant ? w_sel_addr : r_addr;
            mem_wdata   = w_gnt_d ? d_write_data : '0;
            i_valid     = w_i_ret;
            d_valid     = w_d_ret || w_gnt_wr;
            // Returned data is forwarded in the return cycle, then held until the next return.
            i_instr_out = w_i_ret ? mem_rdata : r_i_instr;
            d_data_out  = w_d_ret ? mem_rdata : r_d_data;
            i_stall     = i_read_en && !w_i_ret;
            d_stall     = w_d_req && !(w_d_ret || w_gnt_wr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            r_owner   <= OWN_I;
            r_addr    <= '0;
            r_i_instr <= '0;
            r_d_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt_rd) begin
                // Owner and address are captured at grant; later request changes are ignored.
                r_lat_cnt <= LAT_W'(RD_LATENCY);
                r_owner   <= w_owner;
            end else if (r_state == WAIT) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end
            if (w_grant) begin
                r_addr <= w_sel_addr;
            end
            if (w_i_ret) begin
                r_i_instr <= mem_rdata;
            end
            if (w_d_ret) begin
                r_d_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 with RD_LATENCY=1, instance 1 with RD_LATENCY=3.
// Stimulus pushes expected grants/returns (with their cycle numbers) into per-instance queues;
// a negedge monitor pops and compares whenever mem_en, i_valid or d_valid is seen.
module tb_mem_port_arbiter;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        rst_a        [2];
    logic        i_read_en_a  [2];
    logic [31:0] i_addr_a     [2];
    logic [31:0] i_instr_a    [2];
    logic        i_valid_a    [2];
    logic        i_stall_a    [2];
    logic        d_read_en_a  [2];
    logic        d_write_en_a [2];
    logic [31:0] d_addr_a     [2];
    logic [31:0] d_wdata_a    [2];
    logic [31:0] d_data_a     [2];
    logic        d_valid_a    [2];
    logic        d_stall_a    [2];
    logic        mem_en_a     [2];
    logic        mem_we_a     [2];
    logic [31:0] mem_addr_a   [2];
    logic [31:0] mem_wdata_a  [2];
    logic [31:0] mem_rdata_a  [2];

    exp_t gq [2][$];
    exp_t iq [2][$];
    exp_t dq [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W       (32),
            .DATA_W       (32),
            .RD_LATENCY   ((k == 0) ? 1 : 3),
            .MAX_D_STREAK (4)
        ) u_dut (
            .clk          (clk),
            .rst          (rst_a[k]),
            .i_read_en    (i_read_en_a[k]),
            .i_addr       (i_addr_a[k]),
            .i_instr_out  (i_instr_a[k]),
            .i_valid      (i_valid_a[k]),
            .i_stall      (i_stall_a[k]),
            .d_read_en    (d_read_en_a[k]),
            .d_write_en   (d_write_en_a[k]),
            .d_addr       (d_addr_a[k]),
            .d_write_data (d_wdata_a[k]),
            .d_data_out   (d_data_a[k]),
            .d_valid      (d_valid_a[k]),
            .d_stall      (d_stall_a[k]),
            .mem_en       (mem_en_a[k]),
            .mem_we       (mem_we_a[k]),
            .mem_addr     (mem_addr_a[k]),
            .mem_wdata    (mem_wdata_a[k]),
            .mem_rdata    (mem_rdata_a[k])
        );
    end

    // Memory model: unwritten words read as a fixed function of their address;
    // reads enter a 3-stage pipe, tapped at depth 1 or 3 to match each instance.
    logic [31:0]  mem  [2][256];
    logic [255:0] wv   [2] = '{256'd0, 256'd0};
    logic [31:0]  pipe [2][3];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h2402_000A : (32'hA000_0000 | a);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pipe[k][0] <= 32'hBAD0_BAD0;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
            if (mem_en_a[k]) begin
                if (mem_we_a[k]) begin
                    mem[k][mem_addr_a[k][9:2]] <= mem_wdata_a[k];
                    wv[k][mem_addr_a[k][9:2]]  <= 1'b1;
                end else begin
                    pipe[k][0] <= wv[k][mem_addr_a[k][9:2]] ? mem[k][mem_addr_a[k][9:2]]
                                                            : dflt(mem_addr_a[k]);
                end
            end
        end
    end

    assign mem_rdata_a[0] = pipe[0][0];
    assign mem_rdata_a[1] = pipe[1][2];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input int k);
        total++;
        bad++;
        $display("FAIL %s%0d: unexpected pulse at cyc %0d (nothing expected)", nm, k, cyc);
    endtask

    function automatic logic [159:0] outs(input int k);
        return {26'd0, i_instr_a[k], i_valid_a[k], i_stall_a[k], d_data_a[k], d_valid_a[k],
                d_stall_a[k], mem_en_a[k], mem_we_a[k], mem_addr_a[k], mem_wdata_a[k]};
    endfunction

    task automatic pg(input int k, input int c, input logic wr, input logic [31:0] a);
        exp_t e;
        e.cyc = c; e.wr = wr; e.dat = a;
        gq[k].push_back(e);
    endtask

    task automatic pi(input int k, input int c, input logic [31:0] d);
        exp_t e;
        e.cyc = c; e.wr = 1'b0; e.dat = d;
        iq[k].push_back(e);
    endtask

    task automatic pd(input int k, input int c, input logic wr, input logic [31:0] d);
        exp_t e;
        e.cyc = c; e.wr = wr; e.dat = d;
        dq[k].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every grant and every return must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (mem_en_a[k]) begin
                if (gq[k].size() == 0) unexp("grant", k);
                else begin
                    e = gq[k].pop_front();
                    chk($sformatf("grant%0d", k), {32'(cyc), mem_we_a[k], mem_addr_a[k]},
                        {32'(e.cyc), e.wr, e.dat});
                end
            end
            if (i_valid_a[k]) begin
                if (iq[k].size() == 0) unexp("i_valid", k);
                else begin
                    e = iq[k].pop_front();
                    chk($sformatf("i_ret%0d", k), {32'(cyc), i_instr_a[k]}, {32'(e.cyc), e.dat});
                end
            end
            if (d_valid_a[k]) begin
                if (dq[k].size() == 0) unexp("d_valid", k);
                else begin
                    e = dq[k].pop_front();
                    if (e.wr)
                        chk($sformatf("d_wr%0d", k), {32'(cyc), mem_we_a[k], d_stall_a[k]},
                            {32'(e.cyc), 1'b1, 1'b0});
                    else
                        chk($sformatf("d_ret%0d", k), {32'(cyc), d_data_a[k]}, {32'(e.cyc), e.dat});
                end
            end
        end
    end

    initial begin
        int c;
        for (int k = 0; k < 2; k++) begin
            rst_a[k] = 1'b0; i_read_en_a[k] = 1'b0; i_addr_a[k] = '0;
            d_read_en_a[k] = 1'b0; d_write_en_a[k] = 1'b0; d_addr_a[k] = '0; d_wdata_a[k] = '0;
        end

        // Reset with all requests high on instance 0: every output must stay 0.
        i_read_en_a[0] = 1'b1; i_addr_a[0] = 32'h104;
        d_read_en_a[0] = 1'b1; d_addr_a[0] = 32'h300;
        for (int r = 0; r < 4; r++) begin
            tick();
            @(negedge clk);
            chk("reset_outs0", outs(0), '0);
        end

        // Release with continuous data reads and fetches: D,D,D,D,I,D,D,D,D,I.
        tick();
        rst_a[0] = 1'b1; rst_a[1] = 1'b1;
        c = cyc;
        for (int j = 0; j < 10; j++) begin
            if (j == 4 || j == 9) begin
                pg(0, c + j, 1'b0, 32'h104);
                pi(0, c + j + 1, 32'hA000_0104);
            end else begin
                pg(0, c + j, 1'b0, 32'h300);
                pd(0, c + j + 1, 1'b0, 32'hA000_0300);
            end
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("streak_stalls", {30'd0, i_stall_a[0], d_stall_a[0]},
                {30'd0, (j != 5), (j == 0 || j == 5)});
            tick();
        end
        i_read_en_a[0] = 1'b0; d_read_en_a[0] = 1'b0;
        repeat (3) tick();

        // Single fetch of 0x100, latency 1.
        c = cyc;
        i_read_en_a[0] = 1'b1; i_addr_a[0] = 32'h100;
        pg(0, c, 1'b0, 32'h100);
        pi(0, c + 1, 32'h2402_000A);
        @(negedge clk);
        chk("fetch_stall0", {31'd0, i_stall_a[0]}, 160'd1);
        tick();
        i_read_en_a[0] = 1'b0;
        @(negedge clk);
        chk("fetch_stall1", {30'd0, i_stall_a[0], i_valid_a[0]}, 160'd1);
        repeat (2) tick();

        // Zero-latency write then read-back of the same word.
        c = cyc;
        d_write_en_a[0] = 1'b1; d_addr_a[0] = 32'h200; d_wdata_a[0] = 32'hDEAD_BEEF;
        pg(0, c, 1'b1, 32'h200);
        pd(0, c, 1'b1, 32'h0);
        @(negedge clk);
        chk("write_stall", {30'd0, d_stall_a[0], d_valid_a[0]}, 160'd1);
        tick();
        d_write_en_a[0] = 1'b0; d_read_en_a[0] = 1'b1;
        pg(0, c + 1, 1'b0, 32'h200);
        pd(0, c + 2, 1'b0, 32'hDEAD_BEEF);
        tick();
        d_read_en_a[0] = 1'b0;
        repeat (3) tick();

        // Latency 3: back-to-back fetches, address change during WAIT ignored.
        c = cyc;
        i_read_en_a[1] = 1'b1; i_addr_a[1] = 32'h104;
        pg(1, c, 1'b0, 32'h104);
        pg(1, c + 3, 1'b0, 32'h108);
        pi(1, c + 3, 32'hA000_0104);
        pi(1, c + 6, 32'hA000_0108);
        tick();
        i_addr_a[1] = 32'h108;
        @(negedge clk);
        chk("lat3_stall_wait", {31'd0, i_stall_a[1]}, 160'd1);
        repeat (2) tick();
        @(negedge clk);
        chk("lat3_stall_ret", {31'd0, i_stall_a[1]}, 160'd0);
        tick();
        i_read_en_a[1] = 1'b0;
        repeat (4) tick();

        // Read+write together: one write, no read return; then read it back,
        // dropping the request while the read is outstanding.
        c = cyc;
        d_read_en_a[1] = 1'b1; d_write_en_a[1] = 1'b1;
        d_addr_a[1] = 32'h240; d_wdata_a[1] = 32'h1234_5678;
        pg(1, c, 1'b1, 32'h240);
        pd(1, c, 1'b1, 32'h0);
        tick();
        d_read_en_a[1] = 1'b0; d_write_en_a[1] = 1'b0;
        repeat (5) tick();
        c = cyc;
        d_read_en_a[1] = 1'b1;
        pg(1, c, 1'b0, 32'h240);
        pd(1, c + 3, 1'b0, 32'h1234_5678);
        tick();
        d_read_en_a[1] = 1'b0;
        repeat (5) tick();

        // Reset one cycle after a read grant: stale data ignored, fresh fetch granted at release.
        c = cyc;
        d_read_en_a[1] = 1'b1; d_addr_a[1] = 32'h300;
        pg(1, c, 1'b0, 32'h300);
        tick();
        rst_a[1] = 1'b0;
        i_read_en_a[1] = 1'b1; i_addr_a[1] = 32'h10C;
        @(negedge clk);
        chk("reset_outs1", outs(1), '0);
        tick();
        rst_a[1] = 1'b1; d_read_en_a[1] = 1'b0;
        pg(1, c + 2, 1'b0, 32'h10C);
        pi(1, c + 5, 32'hA000_010C);
        tick();
        i_read_en_a[1] = 1'b0;
        repeat (6) tick();

        for (int k = 0; k < 2; k++) begin
            chk($sformatf("left%0d", k),
                {128'd0, 32'(gq[k].size() + iq[k].size() + dq[k].size())}, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the pipeline's instruction-fetch port and its data port.
- Replaces the dual-port memory when the system is built on single-port RAM.
- Sits between the pipeline and the memory. It arbitrates, sequences read latency, returns data and drives per-port stall signals back to the pipeline.
- Data port has priority; a streak limiter guarantees fetch progress.

Parameters:
ADDR_W, 32, address width of both requester ports and the memory port
DATA_W, 32, data/instruction width
RD_LATENCY, 1, cycles from memory enable to valid mem_rdata (legal 1..4)
MAX_D_STREAK, 4, max consecutive data grants while a fetch is waiting (legal 1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
i_read_en  in  1  fetch request
i_addr  in  ADDR_W  fetch address
i_instr_out  out  DATA_W  fetched instruction, valid when i_valid
i_valid  out  1  one-cycle pulse: fetch data returned
i_stall  out  1  fetch request pending, not yet completed
d_read_en  in  1  data read request
d_write_en  in  1  data write request
d_addr  in  ADDR_W  data address
d_write_data  in  DATA_W  write data
d_data_out  out  DATA_W  load data, valid when d_valid
d_valid  out  1  one-cycle pulse: load data returned, or write accepted
d_stall  out  1  data request pending, not yet completed
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable (qualified by mem_en)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, RD_LATENCY cycles after mem_en

Behaviour:
- Reset: clk, rst synchronous active-low. While rst=0, all outputs are 0 and the FSM goes to IDLE. The streak counter and latency counter are cleared. An outstanding read is abandoned; mem_rdata arriving after reset is ignored.
- FSM states are IDLE and WAIT. One transaction is outstanding at most.
- IDLE with any request: grant is issued combinationally in the same cycle.
  - mem_en=1; mem_addr/mem_we/mem_wdata are taken from the granted port.
- Arbitration:
  - Data is granted if d_read_en or d_write_en is asserted, unless i_read_en=1 and streak==MAX_D_STREAK; then fetch is granted.
  - Otherwise fetch is granted if i_read_en=1.
- Streak counter:
  - +1 on each data grant while i_read_en=1.
  - Cleared on a fetch grant, or in any cycle with i_read_en=0.
  - Saturates at MAX_D_STREAK.
- Write grant:
  - mem_we=1; d_valid pulses in the grant cycle itself; FSM stays IDLE (zero added latency).
- Read grant:
  - FSM goes to WAIT; latency counter loads RD_LATENCY.
  - Counter decrements each cycle. When it reaches 0, mem_rdata is routed to the granted port's data output with a one-cycle valid pulse.
  - In that same cycle the FSM returns to IDLE and may grant the next request.
  - Back-to-back reads therefore run every RD_LATENCY cycles.
- Data outputs hold their last returned value until the next return.
- Stall:
  - x_stall = x request asserted AND NOT (x completes this cycle).
  - Completes means x_valid=1 in that cycle.
  - Requesters hold request, address and data stable while stalled.
- d_read_en and d_write_en both high: treated as a write; the read is dropped.
- Address and data changes while a read is in WAIT are ignored. The granted address is latched at grant.
- Request deasserted while WAIT for that port: the read still completes and the valid pulse is still issued. Consumers tolerate it.
- In WAIT, mem_en=0 (no pipelined issue).

Decomposition:
- Shared package mips_mem_pkg holds:
  - state enum {IDLE, WAIT}
  - grant-owner encoding {OWN_I, OWN_D}
  - RD_LATENCY bounds
- One natural sub-module: mem_grant_select. It is combinational priority plus the streak counter, and outputs owner and grant.
- Latency counter, return mux and stalls remain in the top module.

Test Plan:
- Reset, RD_LATENCY=1: hold rst=0 4 cycles with all requests high -> all outputs 0. Release -> data granted first cycle; mem_en=1; mem_addr=d_addr.
- Fetch only, i_addr=0x100, memory returns 0x2402000A -> mem_en one cycle; i_instr_out=0x2402000A with i_valid at the next edge; i_stall high exactly 1 cycle.
- Streak limit, MAX_D_STREAK=4: continuous data reads plus continuous fetch -> grant order D,D,D,D,I,D,D,D,D,I. No fetch starvation.
- Write, d_write_en=1, d_addr=0x200, data 0xDEADBEEF -> mem_we=1 and d_valid in the same cycle; d_stall=0. A following read of 0x200 returns 0xDEADBEEF.
- RD_LATENCY=3: two back-to-back fetches -> mem_en cycles 0 and 3; i_valid in cycles 3 and 6. d_read_en and d_write_en both high -> a single write, no read return.
- Reset mid-WAIT: assert rst=0 one cycle after a read grant -> no i_valid/d_valid afterwards; stale mem_rdata ignored; fresh request granted right after release.
